xor_share_sched: RTL
====================

# xor_share_sched

Round-robin scheduler that shares one single-bit XOR gate unit between two requesters. Each requester submits a W-bit operand pair. The scheduler serialises the pair bit-by-bit through the external XOR unit, waiting a programmable settle time per bit so the gate-delay chain resolves. It returns the W-bit result with a one-cycle done pulse tagged with the requester ID.

## Interface
- W, default 8: operand/result width, ≥1.
- SETTLE, default 2: idle cycles between driving unit inputs and sampling unit output, ≥0.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 request; held high until gnt0.
- a0, b0  in  W  requester 0 operands; valid while req0 high.
- req1  in  1  requester 1 request.
- a1, b1  in  W  requester 1 operands.
- gnt0, gnt1  out  1  one-cycle grant pulse; operands captured on the granting edge.
- busy  out  1  high whenever state ≠ IDLE.
- xu_a, xu_b  out  1  registered inputs to the shared XOR unit.
- xu_y  in  1  XOR unit output.
- result  out  W  last completed result; holds until the next done.
- done  out  1  one-cycle completion pulse.
- done_id  out  1  requester served by the current/last done.

## Operation
- State machine: IDLE → RUN → DONE → IDLE.
- IDLE, at an edge with any req high:
  - Pick a winner.
  - Latch its a/b into opA/opB.
  - Assert the winner's gnt for the following cycle.
  - Set bit=0, cnt=0, xu_a=opA[0], xu_b=opB[0], id=winner.
  - Go to RUN.
- Arbitration:
  - Single requester wins.
  - If both request, the one not served last wins (pointer last).
  - last updates to the winner at the grant edge.
- RUN, each edge:
  - If cnt==SETTLE:
    - result_sh[bit] ← xu_y.
    - If bit==W-1, go to DONE.
    - Otherwise bit+1, cnt=0, and xu_a/xu_b ← next operand bits.
  - Otherwise cnt+1.
- DONE, entry edge: result ← assembled value, done=1, done_id=id.
- DONE, next edge: go to IDLE, done=0.
- Requests are ignored outside IDLE. A req still high after its gnt counts as a new request at the next IDLE evaluation.
- result bit k = xu_y sampled for bit k; the LSB is processed first.
- xu_a/xu_b hold their last driven values in DONE/IDLE.

## Timing
- Reset (sync, sampled at an edge with rst=1):
  - state=IDLE, last=1 (req0 wins the first contention).
  - gnt0=gnt1=busy=done=done_id=0, xu_a=xu_b=0, result=0, cnt=bit=0.
- rst overrides every other condition.
- Reset mid-RUN aborts the operation: no done, result keeps 0.
- Grant edge = E0. gnt high and busy high during cycle E0..E0+1.
- Bit k inputs are driven from edge E0+k(SETTLE+1). Bit k is sampled at edge E0+(k+1)(SETTLE+1). The XOR unit therefore gets SETTLE+1 full cycles per bit.
- done is high from edge E0+W(SETTLE+1)+1 for exactly one cycle.
- busy is low again after edge E0+W(SETTLE+1)+2.
- Earliest next grant is at edge E0+W(SETTLE+1)+3. Back-to-back period is W(SETTLE+1)+3 cycles.
- With W=8, SETTLE=2:
  - last sample at E0+24.
  - done at E0+25.
  - IDLE at E0+26.
  - next grant at E0+27.
- Simultaneous req0/req1 in IDLE: exactly one gnt; never both in the same cycle.

## Test plan
- Bench XOR model: outputs X for SETTLE cycles after an input change, then a^b. Premature sampling must show up as X in result.
- Single op, W=8, SETTLE=2: req0, a0=0xA5, b0=0x3C.
  - gnt0 pulse one cycle after the request edge.
  - done 25 cycles after the grant edge.
  - result=0x99, done_id=0.
- Contention from reset: req0 and req1 raised in the same cycle (a1=0xFF, b1=0x0F).
  - gnt0 first, then gnt1 27 cycles after gnt0.
  - Results 0x99 (id 0), then 0xF0 (id 1).
- Fairness: both reqs held continuously for 6 operations.
  - Grants alternate 0,1,0,1,0,1.
  - Every consecutive grant pair is spaced 27 cycles apart.
- SETTLE=0, W=4: a=0x6, b=0x3.
  - result=0x5.
  - done 5 cycles after the grant edge.
  - The X-model confirms no sampling before settle.
- Reset mid-RUN: assert rst at E0+10 for one cycle.
  - No done.
  - All outputs at reset values the cycle after.
  - A fresh req1 afterwards is granted and completes correctly.

Source files
------------

// File: rtl/xor_share_sched.sv
// Round-robin sharing of one external single-bit XOR unit between two requesters.
// Operands are pushed through the unit LSB first, allowing SETTLE extra cycles per bit.
module xor_share_sched #(
    parameter int W      = 8,
    parameter int SETTLE = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_req0,
    input  logic [W-1:0] i_a0,
    input  logic [W-1:0] i_b0,
    input  logic         i_req1,
    input  logic [W-1:0] i_a1,
    input  logic [W-1:0] i_b1,
    output logic         o_gnt0,
    output logic         o_gnt1,
    output logic         o_busy,
    output logic         o_xu_a,
    output logic         o_xu_b,
    input  logic         i_xu_y,
    output logic [W-1:0] o_result,
    output logic         o_done,
    output logic         o_done_id
);
    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         r_state;
    logic           r_last;
    logic           r_id;
    logic [W-1:0]   r_op_a;
    logic [W-1:0]   r_op_b;
    logic [W-1:0]   r_res_sh;
    logic [BW-1:0]  r_bit;
    logic [CW-1:0]  r_cnt;
    logic           r_gnt0;
    logic           r_gnt1;
    logic           r_xu_a;
    logic           r_xu_b;
    logic [W-1:0]   r_result;
    logic           r_done;
    logic           r_done_id;

    logic           w_any;
    logic           w_win;
    logic [BW-1:0]  w_bit_nxt;

    assign w_any     = i_req0 | i_req1;
    // On contention the requester not served last wins; otherwise the lone requester
    assign w_win     = (i_req0 & i_req1) ? ~r_last : i_req1;
    assign w_bit_nxt = r_bit + BW'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_id      <= 1'b0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_res_sh  <= '0;
            r_bit     <= '0;
            r_cnt     <= '0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_xu_a    <= 1'b0;
            r_xu_b    <= 1'b0;
            r_result  <= '0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
        end else begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_op_a  <= w_win ? i_a1 : i_a0;
                        r_op_b  <= w_win ? i_b1 : i_b0;
                        r_xu_a  <= w_win ? i_a1[0] : i_a0[0];
                        r_xu_b  <= w_win ? i_b1[0] : i_b0[0];
                        r_gnt0  <= ~w_win;
                        r_gnt1  <= w_win;
                        r_last  <= w_win;
                        r_id    <= w_win;
                        r_bit   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_cnt == CW'(SETTLE)) begin
                        r_res_sh[r_bit] <= i_xu_y;
                        if (r_bit == BW'(W - 1)) begin
                            r_state <= S_DONE;
                        end else begin
                            r_bit  <= w_bit_nxt;
                            r_cnt  <= '0;
                            r_xu_a <= r_op_a[w_bit_nxt];
                            r_xu_b <= r_op_b[w_bit_nxt];
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    // First DONE edge publishes the result, second returns to IDLE
                    if (!r_done) begin
                        r_result  <= r_res_sh;
                        r_done    <= 1'b1;
                        r_done_id <= r_id;
                    end else begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_gnt0    = r_gnt0;
    assign o_gnt1    = r_gnt1;
    assign o_busy    = (r_state != S_IDLE);
    assign o_xu_a    = r_xu_a;
    assign o_xu_b    = r_xu_b;
    assign o_result  = r_result;
    assign o_done    = r_done;
    assign o_done_id = r_done_id;
endmodule
